// File: rtl/phasenoisepon_rot13_host_if.sv
// phasenoisepon_rot13_host_if: request/result streams plus the core's io pins.
interface phasenoisepon_rot13_host_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic [1:0] out_status;
  logic [7:0] core_io_in;
  logic [7:0] core_io_out;
  modport master (
    output in_valid, in_byte, out_ready, core_io_out,
    input  in_ready, out_valid, out_byte, out_status, core_io_in
  );
  modport slave (
    input  in_valid, in_byte, out_ready, core_io_out,
    output in_ready, out_valid, out_byte, out_status, core_io_in
  );
endinterface

// File: rtl/phasenoisepon_rot13_host.sv
// phasenoisepon_rot13_host: bit-bangs one byte at a time through the nibble-protocol ROT13 core.
module phasenoisepon_rot13_host #(
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 2
) (
  input logic                         clk,
  input logic                         reset_n,
  phasenoisepon_rot13_host_if.slave   bus
);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV);
  localparam logic [RW-1:0] RC_LAST = RW'(RST_CYCLES - 1);
  typedef enum logic [2:0] {CORE_RST, IDLE, LO, HI, XL, DONE} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [7:0]    byte_q, byte_d, ob_q, ob_d, io_q, io_d;
  logic [1:0]    st_q, st_d;
  logic          stepping, step_end;
  assign stepping = state_q inside {CORE_RST, LO, HI, XL};
  assign step_end = stepping && (ph_q == PH_LAST);
  assign bus.in_ready   = state_q == IDLE;
  assign bus.out_valid  = state_q == DONE;
  assign bus.out_byte   = ob_q;
  assign bus.out_status = st_q;
  assign bus.core_io_in = io_q;
  // Step sequencing: the phase counter runs only inside a core-clock pulse; the core's reply is taken on the last phase.
  always_comb begin
    state_d = state_q;
    ph_d    = stepping ? (step_end ? '0 : ph_q + 1'b1) : '0;
    rc_d    = rc_q;
    byte_d  = byte_q;
    ob_d    = ob_q;
    st_d    = st_q;
    case (state_q)
      CORE_RST: if (step_end) begin
        rc_d    = rc_q + 1'b1;
        state_d = rc_q == RC_LAST ? IDLE : CORE_RST;
      end
      IDLE: if (bus.in_valid) begin
        byte_d  = bus.in_byte;
        st_d    = 2'b00;
        state_d = LO;
      end
      LO: if (step_end) begin
        st_d[0] = st_q[0] | (bus.core_io_out != 8'h0F);
        state_d = HI;
      end
      HI: if (step_end) begin
        st_d[0] = st_q[0] | (bus.core_io_out != 8'hF0);
        state_d = XL;
      end
      XL: if (step_end) begin
        ob_d    = bus.core_io_out;
        st_d[1] = bus.core_io_out == 8'h00;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = CORE_RST;
    endcase
  end
  // Pin image for the next cycle; the pins are registered so the core clock never glitches and [7:1] only move with clk low.
  always_comb begin
    io_d      = 8'h00;
    io_d[0]   = (state_d inside {CORE_RST, LO, HI, XL}) && (ph_d >= PH_HI);
    io_d[1]   = state_d == CORE_RST;
    io_d[3:2] = state_d == HI ? 2'b01 : state_d == XL ? 2'b10 : 2'b00;
    io_d[7:4] = state_d == LO ? byte_d[3:0] : state_d == HI ? byte_d[7:4] : 4'h0;
  end
  // State and pin registers; reset parks the core in reset with its clock low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CORE_RST;
      ph_q    <= '0;
      rc_q    <= '0;
      byte_q  <= 8'h00;
      ob_q    <= 8'h00;
      st_q    <= 2'b00;
      io_q    <= 8'h02;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rc_q    <= rc_d;
      byte_q  <= byte_d;
      ob_q    <= ob_d;
      st_q    <= st_d;
      io_q    <= io_d;
    end
  end
endmodule

// File: tb/tb_phasenoisepon_rot13_host.sv
// tb_phasenoisepon_rot13_host: directed scoreboard bench with a behavioural nibble-protocol ROT13 core.
module tb_phasenoisepon_rot13_host;
  localparam int CLK_DIV = 4;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         rst_edges = 0;
  int         xfer_edges = 0;
  int         viol = 0;
  logic       fault_lo = 1'b0;
  logic [7:0] core_b = 8'h00;
  logic [7:0] prev_io = 8'h02;
  logic [9:0] sb[$];
  phasenoisepon_rot13_host_if bus();
  phasenoisepon_rot13_host #(.CLK_DIV(CLK_DIV), .RST_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] rot13(input logic [7:0] c);
    int v;
    v = int'(c);
    if (v >= 97 && v <= 122) return 8'((v - 97 + 13) % 26 + 97);
    if (v >= 65 && v <= 90) return 8'((v - 65 + 13) % 26 + 65);
    return 8'h00;
  endfunction
  // Behavioural core: acts on each rising edge of its bit-banged clock.
  always @(posedge bus.core_io_in[0]) begin
    if (bus.core_io_in[1]) begin
      rst_edges++;
      core_b <= 8'h00;
      bus.core_io_out <= 8'h00;
    end else begin
      xfer_edges++;
      case (bus.core_io_in[3:2])
        2'b00: begin core_b[3:0] <= bus.core_io_in[7:4]; bus.core_io_out <= fault_lo ? 8'h00 : 8'h0F; end
        2'b01: begin core_b[7:4] <= bus.core_io_in[7:4]; bus.core_io_out <= 8'hF0; end
        2'b10: bus.core_io_out <= rot13(core_b);
        default: bus.core_io_out <= 8'hFF;
      endcase
    end
  end
  // Data/control pins must hold while the core clock stays high.
  always @(negedge clk) begin
    if (prev_io[0] && bus.core_io_in[0] && bus.core_io_in[7:1] !== prev_io[7:1]) viol++;
    prev_io = bus.core_io_in;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask
  task automatic send(input logic [7:0] b, input logic flt, input int hold);
    string      t;
    int         n;
    logic       busy_bad, hold_bad;
    logic [9:0] exp, held;
    t = $sformatf("b%02h", b);
    wait_ready(t);
    fault_lo = flt;
    sb.push_back({rot13(b) == 8'h00, flt, rot13(b)});
    bus.in_byte = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    xfer_edges = 0;
    bus.in_byte = 8'h7A;
    n = 1;
    busy_bad = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
      if (n == 20) bus.in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check({t, "_latency"}, 32'(n), 32'(1 + 6 * CLK_DIV));
    check({t, "_busy_in_ready"}, 32'(busy_bad), 32'd0);
    check({t, "_core_steps"}, 32'(xfer_edges), 32'd3);
    if (hold > 0) begin
      held = {bus.out_status, bus.out_byte};
      hold_bad = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if ({bus.out_status, bus.out_byte} !== held || bus.in_ready !== 1'b0 ||
            bus.core_io_in[0] !== 1'b0 || bus.out_valid !== 1'b1) hold_bad = 1'b1;
      end
      check({t, "_done_hold"}, 32'(hold_bad), 32'd0);
    end
    if (sb.size() == 0) check({t, "_sb_empty"}, 32'(sb.size()), 32'd1);
    else begin
      exp = sb.pop_front();
      check({t, "_out_byte"}, 32'(bus.out_byte), 32'(exp[7:0]));
      check({t, "_out_status"}, 32'(bus.out_status), 32'(exp[9:8]));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({t, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({t, "_back_idle"}, 32'(bus.in_ready), 32'd1);
    fault_lo = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int   n;
    logic ov_bad;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_core_io_in", 32'(bus.core_io_in), 32'h02);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bus", 32'({bus.out_status, bus.out_byte}), 32'd0);
    reset_n = 1'b1;
    wait_ready("boot");
    check("boot_rst_pulses", 32'(rst_edges), 32'd2);
    check("idle_core_io_in", 32'(bus.core_io_in), 32'h00);
    send(8'h61, 1'b0, 0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    check("stray_out_ready", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    send(8'h5A, 1'b0, 0);
    send(8'h21, 1'b0, 0);
    send(8'h41, 1'b1, 0);
    send(8'h62, 1'b0, 20);
    send(8'h7A, 1'b0, 0);
    wait_ready("pre_abort");
    bus.in_byte = 8'h61;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("mid_hi_pins", 32'({bus.core_io_in[3:2], bus.core_io_in[0]}), 32'b011);
    reset_n = 1'b0;
    #1;
    check("abort_core_io_in", 32'(bus.core_io_in), 32'h02);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    rst_edges = 0;
    ov_bad = bus.out_valid;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ov_bad = 1'b1;
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ov_bad = 1'b1;
    end
    check("abort_no_out_valid", 32'(ov_bad), 32'd0);
    check("abort_rst_pulses", 32'(rst_edges), 32'd2);
    send(8'h6D, 1'b0, 0);
    check("pins_stable_clk_high", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
